microcode_sequencer_stack: RTL

Parametrised microcode address sequencer with a hardware micro-call stack. It replaces the fixed 14-bit sequencer and adds the following:
- signed relative branches
- conditional and unconditional micro-subroutine call and return
- a hold opcode
- a stall input
- sticky stack-error reporting

It sits between the control-word latch (which supplies type/offset/condition fields) and the microcode ROM address input.

---
 rtl/pa_microcode.sv | 27 ++
 rtl/useq_call_stack.sv | 51 +++++
 rtl/microcode_sequencer_stack.sv | 108 ++++++++++
 3 files changed

// File: rtl/pa_microcode.sv
// rtl/pa_microcode.sv - shared opcode encodings and condition indices for the microcode sequencer
package pa_microcode;

  typedef enum logic [2:0] {
    JMP    = 3'd0,
    BR     = 3'd1,
    FETCH  = 3'd2,
    DECODE = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5,
    CCALL  = 3'd6,
    HOLD   = 3'd7
  } useq_typ_t;

  localparam int ZF   = 0;
  localparam int CF   = 1;
  localparam int SF   = 2;
  localparam int OF   = 3;
  localparam int DMA  = 4;
  localparam int MODE = 5;
  localparam int WAIT = 6;
  localparam int INT  = 7;
  localparam int EXT  = 8;
  localparam int DIR  = 9;
  localparam int DREG = 10;

endpackage

// File: rtl/useq_call_stack.sv
// rtl/useq_call_stack.sv - register-array LIFO holding micro-call return addresses
module useq_call_stack #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_stall,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [DW-1:0]    o_depth,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_depth == DW'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign w_do_push = i_push && !i_stall && !o_full;
  assign w_do_pop  = i_pop && !i_stall && !o_empty;
  assign o_ovf     = i_push && !i_stall && o_full;
  assign o_unf     = i_pop && !i_stall && o_empty;
  assign w_wr_idx  = AW'(r_depth);
  assign w_rd_idx  = AW'(r_depth - 1'b1);
  assign o_depth   = r_depth;
  assign o_pop_data = o_empty ? '0 : r_mem[w_rd_idx];

  // Storage is deliberately left out of reset; only the depth pointer is cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_push_data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)           r_depth <= '0;
    else if (w_do_push) r_depth <= r_depth + 1'b1;
    else if (w_do_pop)  r_depth <= r_depth - 1'b1;
  end

endmodule

// File: rtl/microcode_sequencer_stack.sv
// rtl/microcode_sequencer_stack.sv - microcode address sequencer with relative branches and a micro-call stack
module microcode_sequencer_stack
  import pa_microcode::*;
#(
  parameter  int UADDR_W     = 14,
  parameter  int OFFSET_W    = 7,
  parameter  int IR_W        = 8,
  parameter  int NUM_COND    = 16,
  parameter  int STACK_DEPTH = 4,
  parameter  int RESET_ADDR  = 0,
  localparam int CSW         = $clog2(NUM_COND),
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                stall,
  input  useq_typ_t           typ,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [NUM_COND-1:0] cond_in,
  input  logic [CSW-1:0]      cond_sel,
  input  logic                cond_invert,
  input  logic                irq_req,
  input  logic [IR_W-1:0]     ir,
  input  logic [UADDR_W-1:0]  fetch_addr,
  input  logic [UADDR_W-1:0]  trap_addr,
  input  logic                clear_err,
  output logic [UADDR_W-1:0]  u_address,
  output logic                cond_taken,
  output logic [DW-1:0]       stack_depth,
  output logic                stack_ovf,
  output logic                stack_unf
);

  logic [UADDR_W-1:0] r_ua;
  logic               r_ovf;
  logic               r_unf;
  logic [UADDR_W-1:0] w_tgt;
  logic [UADDR_W-1:0] w_inc;
  logic [UADDR_W-1:0] w_next;
  logic [UADDR_W-1:0] w_pop_data;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_ovf;
  logic               w_unf;

  assign cond_taken = cond_in[cond_sel] ^ cond_invert;
  assign w_tgt      = r_ua + {{(UADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign w_inc      = r_ua + 1'b1;
  assign w_push     = (typ == CALL) || ((typ == CCALL) && cond_taken);
  assign w_pop      = (typ == RET);

  useq_call_stack #(
    .WIDTH (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .arst        (arst),
    .i_stall     (stall),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_inc),
    .o_pop_data  (w_pop_data),
    .o_depth     (stack_depth),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ovf       (w_ovf),
    .o_unf       (w_unf)
  );

  always_comb begin
    w_next = r_ua;
    case (typ)
      JMP:     w_next = w_tgt;
      BR:      w_next = cond_taken ? w_tgt : w_inc;
      FETCH:   w_next = irq_req ? trap_addr : fetch_addr;
      DECODE:  w_next = UADDR_W'(ir);
      CALL:    w_next = w_tgt;
      RET:     w_next = w_empty ? fetch_addr : w_pop_data;
      CCALL:   w_next = cond_taken ? w_tgt : w_inc;
      HOLD:    w_next = r_ua;
      default: w_next = r_ua;
    endcase
  end

  // A new error in the same cycle as clear_err must win, so sets come after the clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ua  <= UADDR_W'(RESET_ADDR);
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!stall) begin
      r_ua <= w_next;
      if (clear_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_ovf && w_full) r_ovf <= 1'b1;
      if (w_unf)           r_unf <= 1'b1;
    end
  end

  assign u_address = r_ua;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule
